// File: rtl/stream_axi_writer.sv
// Drains a 512-bit valid/ready stream into AXI4 write bursts split at 4 KiB boundaries.
// Optional B-response error tracking is enabled by defining STREAM_WR_BRESP_CHECK_EN.
module stream_axi_writer #(
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter int unsigned AXI_ID          = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cfg_valid,
    input  logic [63:0]  cfg_addr,
    input  logic [33:0]  cfg_words,
    input  logic [511:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [15:0]  awid_m,
    output logic [63:0]  awaddr_m,
    output logic [7:0]   awlen_m,
    output logic [2:0]   awsize_m,
    output logic         awvalid_m,
    input  logic         awready_m,
    output logic [511:0] wdata_m,
    output logic [63:0]  wstrb_m,
    output logic         wlast_m,
    output logic         wvalid_m,
    input  logic         wready_m,
    input  logic [15:0]  bid_m,
    input  logic [1:0]   bresp_m,
    input  logic         bvalid_m,
    output logic         bready_m,
    output logic         idle,
    output logic [33:0]  words_written,
    output logic         bresp_err
);

    localparam int unsigned PtrW  = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CntW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned CredW = 5;

    logic [63:0]      aw_addr_q, aw_addr_d;
    logic [33:0]      aw_words_q, aw_words_d;
    logic [33:0]      w_words_q, w_words_d;
    logic [33:0]      words_written_q, words_written_d;
    logic [CredW-1:0] credits_q, credits_d;
    logic [PtrW-1:0]  lf_wr_q, lf_wr_d, lf_rd_q, lf_rd_d;
    logic [CntW-1:0]  lf_cnt_q, lf_cnt_d;
    logic [5:0]       beat_q, beat_d;
    logic [5:0]       lf_mem_q [MAX_OUTSTANDING];

    logic [6:0] room;
    logic [6:0] len;
    logic [5:0] len_m1;
    logic [5:0] head_m1;
    logic       lf_nonempty;
    logic       aw_hs, w_hs, w_last_hs, b_hs, start;

    // Beats left before the next 4 KiB boundary bound every burst.
    assign room    = 7'd64 - {1'b0, aw_addr_q[11:6]};
    assign len     = (aw_words_q < {27'd0, room}) ? aw_words_q[6:0] : room;
    assign len_m1  = 6'(len - 7'd1);
    assign head_m1 = lf_mem_q[lf_rd_q];

    assign lf_nonempty = (lf_cnt_q != '0);

    assign awid_m    = 16'(AXI_ID);
    assign awaddr_m  = aw_addr_q;
    assign awlen_m   = {2'b00, len_m1};
    assign awsize_m  = 3'b110;
    assign awvalid_m = (aw_words_q != '0) && (credits_q != '0);

    assign wdata_m  = in_data;
    assign wstrb_m  = '1;
    assign wvalid_m = in_valid && lf_nonempty;
    assign wlast_m  = lf_nonempty && (beat_q == head_m1);
    assign in_ready = wready_m && lf_nonempty;

    assign bready_m = 1'b1;

    assign aw_hs     = awvalid_m && awready_m;
    assign w_hs      = wvalid_m && wready_m;
    assign w_last_hs = w_hs && wlast_m;
    assign b_hs      = bvalid_m && bready_m;

    assign idle          = (aw_words_q == '0) && (w_words_q == '0) &&
                           (credits_q == CredW'(MAX_OUTSTANDING));
    assign start         = cfg_valid && idle;
    assign words_written = words_written_q;

    always_comb begin
        aw_addr_d       = aw_addr_q;
        aw_words_d      = aw_words_q;
        w_words_d       = w_words_q;
        words_written_d = words_written_q;
        credits_d       = credits_q;
        lf_wr_d         = lf_wr_q;
        lf_rd_d         = lf_rd_q;
        lf_cnt_d        = lf_cnt_q + CntW'(aw_hs) - CntW'(w_last_hs);
        beat_d          = beat_q;

        if (start) begin
            aw_addr_d       = cfg_addr;
            aw_words_d      = cfg_words;
            w_words_d       = cfg_words;
            words_written_d = '0;
        end else begin
            if (aw_hs) begin
                aw_addr_d  = {aw_addr_q[63:12] + 52'd1, 12'h000};
                aw_words_d = aw_words_q - {27'd0, len};
            end
            if (w_hs) begin
                w_words_d       = w_words_q - 34'd1;
                words_written_d = words_written_q + 34'd1;
            end
        end

        case ({aw_hs, b_hs})
            2'b10:   credits_d = credits_q - CredW'(1);
            2'b01:   if (credits_q < CredW'(MAX_OUTSTANDING)) credits_d = credits_q + CredW'(1);
            default: credits_d = credits_q;
        endcase

        if (aw_hs) begin
            lf_wr_d = (lf_wr_q == PtrW'(MAX_OUTSTANDING - 1)) ? '0 : lf_wr_q + PtrW'(1);
        end
        if (w_last_hs) begin
            lf_rd_d = (lf_rd_q == PtrW'(MAX_OUTSTANDING - 1)) ? '0 : lf_rd_q + PtrW'(1);
            beat_d  = '0;
        end else if (w_hs) begin
            beat_d = beat_q + 6'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_addr_q       <= '0;
            aw_words_q      <= '0;
            w_words_q       <= '0;
            words_written_q <= '0;
            credits_q       <= CredW'(MAX_OUTSTANDING);
            lf_wr_q         <= '0;
            lf_rd_q         <= '0;
            lf_cnt_q        <= '0;
            beat_q          <= '0;
        end else begin
            aw_addr_q       <= aw_addr_d;
            aw_words_q      <= aw_words_d;
            w_words_q       <= w_words_d;
            words_written_q <= words_written_d;
            credits_q       <= credits_d;
            lf_wr_q         <= lf_wr_d;
            lf_rd_q         <= lf_rd_d;
            lf_cnt_q        <= lf_cnt_d;
            beat_q          <= beat_d;
        end
    end

    // Stores awlen (len-1) of each issued burst for the W side.
    always_ff @(posedge clk) begin
        if (aw_hs) begin
            lf_mem_q[lf_wr_q] <= len_m1;
        end
    end

`ifdef STREAM_WR_BRESP_CHECK_EN
    logic bresp_err_q, bresp_err_d;
    logic unused_bid;

    assign unused_bid  = ^bid_m;
    assign bresp_err_d = start ? 1'b0 : (bresp_err_q | (b_hs && (bresp_m != 2'b00)));
    assign bresp_err   = bresp_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            bresp_err_q <= 1'b0;
        end else begin
            bresp_err_q <= bresp_err_d;
        end
    end
`else
    logic unused_b;

    assign unused_b  = ^{bid_m, bresp_m};
    assign bresp_err = 1'b0;
`endif

endmodule
